// File: rtl/aes_shiftrow_pipe.sv
// AES ShiftRows/InvShiftRows (per-beat mode), Nb = 4/6/8, with a 2-entry output FIFO.
// Latency: 1 cycle. The permutation happens before storage, and out_data is the registered head entry.
// Backpressure: in_ready is the registered (count < 2), so there is no path from out_ready.

module aes_shiftrow_fifo2 #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;
  logic         push;
  logic         pop;
  logic [1:0]   count_nxt;

  // flush wins over any transfer in the same cycle
  assign push    = push_vld && push_rdy && !flush;
  assign pop     = pop_vld && pop_rdy && !flush;
  assign pop_vld = (count != 2'd0);
  assign pop_dat = mem[rptr];

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = 2'd0;
    else if (push && !pop)
      count_nxt = count + 2'd1;
    else if (pop && !push)
      count_nxt = count - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      count    <= 2'd0;
      push_rdy <= 1'b0;
    end else begin
      if (push)
        mem[wptr] <= push_dat;
      if (flush) begin
        wptr <= 1'b0;
        rptr <= 1'b0;
      end else begin
        if (push)
          wptr <= ~wptr;
        if (pop)
          rptr <= ~rptr;
      end
      count    <= count_nxt;
      push_rdy <= (count_nxt < 2'd2);
    end
  end

endmodule

module aes_shiftrow_pipe #(
  parameter int NB = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*NB-1:0]  in_data,
  input  logic              in_inv,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic [1:0]        count
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shiftrow_pipe: NB must be 4, 6 or 8");
  end

  // Rijndael row offsets; the 256-bit block uses 3 and 4 on the bottom rows
  function automatic int row_shift(input int r);
    return (NB == 8 && r >= 2) ? r + 1 : r;
  endfunction

  // byte (r,c) lives at index 4*c + r, byte 0 in the top bits
  function automatic logic [W-1:0] shift_rows(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] q;
    int           s;
    int           src;
    q = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        s   = row_shift(r);
        src = inv ? (c + NB - s) % NB : (c + s) % NB;
        q[W-1-8*(4*c+r) -: 8] = d[W-1-8*(4*src+r) -: 8];
      end
    end
    return q;
  endfunction

  logic [W-1:0] perm_dat;

  always_comb begin
    perm_dat = shift_rows(in_data, in_inv);
  end

  aes_shiftrow_fifo2 #(
    .W (W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat (perm_dat),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (out_data),
    .count    (count)
  );

endmodule

// File: tb/tb_aes_shiftrow_pipe.sv
// Directed bench for aes_shiftrow_pipe (NB=4 and NB=8 instances) with a queue scoreboard.
module tb_aes_shiftrow_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         iv4, ir4, inv4, fl4, ov4, or4;
  logic [127:0] id4, od4;
  logic [1:0]   cnt4;

  logic         iv8, ir8, inv8, fl8, ov8, or8;
  logic [255:0] id8, od8;
  logic [1:0]   cnt8;

  int total = 0;
  int bad   = 0;
  int npop  = 0;
  logic [255:0] sb [$];

  aes_shiftrow_pipe #(.NB(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_data(id4), .in_inv(inv4),
    .flush(fl4), .out_valid(ov4), .out_ready(or4), .out_data(od4), .count(cnt4)
  );

  aes_shiftrow_pipe #(.NB(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_inv(inv8),
    .flush(fl8), .out_valid(ov8), .out_ready(or8), .out_data(od8), .count(cnt8)
  );

  // Reference: gather into a row/column grid, rotate each row, then scatter back
  function automatic logic [255:0] model(input logic [255:0] d, input int nb, input bit inv);
    logic [7:0]   st [4][8];
    logic [7:0]   nw [4][8];
    int           sh [4];
    logic [255:0] res;
    if (nb == 8) sh = '{0, 1, 3, 4};
    else         sh = '{0, 1, 2, 3};
    for (int k = 0; k < 4*nb; k++) st[k%4][k/4] = d[32*nb-1-8*k -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++)
        if (!inv) nw[r][c] = st[r][(c + sh[r]) % nb];
        else      nw[r][(c + sh[r]) % nb] = st[r][c];
    res = '0;
    for (int k = 0; k < 4*nb; k++) res[32*nb-1-8*k -: 8] = nw[k%4][k/4];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock on the NB=4 instance: sample at negedge, score, then step past the edge
  task automatic cyc();
    @(negedge clk);
    if (fl4) begin
      sb.delete();
    end else begin
      if (ov4 && or4) begin
        npop++;
        if (sb.size() == 0) chk("sb_underflow", 256'd1, 256'd0);
        else chk("data", {128'b0, od4}, sb.pop_front());
      end
      if (iv4 && ir4) sb.push_back(model({128'b0, id4}, 4, inv4));
    end
    @(posedge clk);
    #1;
  endtask

  logic [127:0] kat_a = 128'hd42711aee0bf98f1b8b45de51e415230;
  logic [127:0] kat_b = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  logic [255:0] seq8, r8, tmp;
  logic [127:0] held;
  int gaps, pop0;

  initial begin
    rst = 1'b1;
    {iv4, inv4, fl4, or4} = '0; id4 = '0;
    {iv8, inv8, fl8, or8} = '0; id8 = '0;
    for (int k = 0; k < 32; k++) seq8[255-8*k -: 8] = k[7:0];

    // reset state
    #2;
    chk("rst_count", {254'b0, cnt4}, 256'd0);
    chk("rst_out_valid", {255'b0, ov4}, 256'd0);
    chk("rst_in_ready", {255'b0, ir4}, 256'd0);
    chk("rst_out_data", {128'b0, od4}, 256'd0);
    chk("rst_out_data8", od8, 256'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", {255'b0, ir4}, 256'd1);
    chk("ready_after_rst8", {255'b0, ir8}, 256'd1);

    // known-answer forward and inverse
    iv4 = 1'b1; id4 = kat_a; inv4 = 1'b0; or4 = 1'b1;
    cyc();
    iv4 = 1'b0;
    chk("kat_fwd_valid", {255'b0, ov4}, 256'd1);
    chk("kat_fwd", {128'b0, od4}, {128'b0, kat_b});
    cyc();
    iv4 = 1'b1; id4 = kat_b; inv4 = 1'b1;
    cyc();
    iv4 = 1'b0;
    chk("kat_inv", {128'b0, od4}, {128'b0, kat_a});
    cyc();
    chk("kat_drained", {254'b0, cnt4}, 256'd0);

    // NB=8 forward then inverse
    iv8 = 1'b1; id8 = seq8; inv8 = 1'b0;
    @(posedge clk); #1;
    iv8 = 1'b0;
    r8 = od8;
    tmp = {224'b0, r8[255:224]};
    chk("nb8_col0", tmp, 256'h00050e13);
    chk("nb8_fwd", r8, model(seq8, 8, 1'b0));
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0; iv8 = 1'b1; id8 = r8; inv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    chk("nb8_inv", od8, seq8);

    // backpressure: three offers with out_ready low, only two fit
    or4 = 1'b0; iv4 = 1'b1; inv4 = 1'b0;
    id4 = 128'h000102030405060708090a0b0c0d0e0f; cyc();
    inv4 = 1'b1; id4 = 128'h101112131415161718191a1b1c1d1e1f; cyc();
    held = od4;
    chk("full_count", {254'b0, cnt4}, 256'd2);
    chk("full_ready", {255'b0, ir4}, 256'd0);
    inv4 = 1'b0; id4 = 128'hffeeddccbbaa99887766554433221100; cyc();
    chk("hold_stable", {128'b0, od4}, {128'b0, held});
    // full: a pop in the same cycle still does not admit the offer
    or4 = 1'b1; cyc();
    chk("full_pop_count", {254'b0, cnt4}, 256'd1);
    // count=1: push and pop together keeps one entry, new beat at head
    inv4 = 1'b1; id4 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0; cyc();
    chk("pushpop_count", {254'b0, cnt4}, 256'd1);
    tmp = model({128'b0, id4}, 4, 1'b1);
    chk("pushpop_head", {128'b0, od4}, tmp);
    iv4 = 1'b0; cyc();
    chk("drain_count", {254'b0, cnt4}, 256'd0);

    // 100-beat stream, mixed modes
    gaps = 0; pop0 = npop;
    iv4 = 1'b1; or4 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      id4 = {$urandom, $urandom, $urandom, $urandom};
      inv4 = $urandom_range(0, 1);
      if (i > 0 && !ov4) gaps++;
      cyc();
    end
    iv4 = 1'b0;
    cyc();
    chk("stream_gaps", gaps, 256'd0);
    chk("stream_pops", npop - pop0, 256'd100);

    // flush at count=2 with a simultaneous offer
    or4 = 1'b0; iv4 = 1'b1;
    id4 = 128'h11111111222222223333333344444444; cyc();
    id4 = 128'h55555555666666667777777788888888; cyc();
    chk("pre_flush_count", {254'b0, cnt4}, 256'd2);
    fl4 = 1'b1; id4 = 128'h99999999aaaaaaaabbbbbbbbcccccccc; cyc();
    fl4 = 1'b0; iv4 = 1'b0;
    chk("flush_count", {254'b0, cnt4}, 256'd0);
    chk("flush_valid", {255'b0, ov4}, 256'd0);
    chk("flush_ready", {255'b0, ir4}, 256'd1);

    // asynchronous reset pulse between edges
    iv4 = 1'b1; id4 = kat_a; inv4 = 1'b0; cyc();
    iv4 = 1'b0;
    chk("pre_arst_count", {254'b0, cnt4}, 256'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", {254'b0, cnt4}, 256'd0);
    chk("arst_valid", {255'b0, ov4}, 256'd0);
    chk("arst_ready", {255'b0, ir4}, 256'd0);
    chk("arst_data", {128'b0, od4}, 256'd0);
    sb.delete();
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_arst_ready", {255'b0, ir4}, 256'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_shiftrow_pipe.md
AES_SHIFTROW_PIPE -- requirements
Module: aes_shiftrow_pipe

Interface
REQ-001 The block SHALL have parameter NB, default 4: state columns (Rijndael Nb); legal values 4, 6, 8; block width W = 32*NB.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: producer offers in_data/in_inv.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept a beat.
REQ-006 The block SHALL have port in_data, input, W bits: state bytes A0..A(4NB-1), A0 at [W-1:W-8], column-major (byte index = 4*c + r).
REQ-007 The block SHALL have port in_inv, input, 1 bit: 0 = ShiftRows, 1 = InvShiftRows, per beat.
REQ-008 The block SHALL have port flush, input, 1 bit: synchronous discard of all buffered beats.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-011 The block SHALL have port out_data, output, W bits: permuted state, same byte layout as in_data.
REQ-012 The block SHALL have port count, output, 2 bits: number of buffered beats, 0..2.

Function
REQ-013 Row shift offsets s(r) SHALL be {0,1,2,3} for NB=4 and NB=6, and {0,1,3,4} for NB=8.
REQ-014 Forward output byte (r,c) SHALL equal input byte (r,(c+s(r)) mod NB).
REQ-015 Inverse output byte (r,c) SHALL equal input byte (r,(c-s(r)) mod NB).
REQ-016 The permutation SHALL be applied before storage; a beat SHALL be stored with its own in_inv, so mode switches between consecutive beats take effect without bubbles.
REQ-017 Storage SHALL be a 2-entry FIFO; a beat is accepted when in_valid && in_ready and popped when out_valid && out_ready.
REQ-018 in_ready SHALL equal (count < 2), registered-only, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal (count != 0); out_data SHALL be the head entry, registered.
REQ-020 Latency SHALL be 1 cycle: a beat accepted at edge N is visible on out_data/out_valid after edge N.
REQ-021 With count=2, an input beat SHALL NOT be accepted even if a pop occurs in the same cycle.
REQ-022 A simultaneous push and pop with count=1 SHALL leave count=1, with the new beat at the head after the edge.
REQ-023 Sustained in_valid=1 and out_ready=1 SHALL give one result per cycle.
REQ-024 When out_ready=0, out_data SHALL hold stable while out_valid=1.
REQ-025 Write and read pointers SHALL be 1 bit each and wrap modulo 2.
REQ-026 flush=1 SHALL set count to 0 and both pointers to 0 at the next edge.
REQ-027 flush=1 SHALL override any push or pop in the same cycle; a beat presented that cycle is dropped.
REQ-028 An illegal NB SHALL be rejected at elaboration.

Reset
REQ-029 While rst=1: count=0, out_valid=0, in_ready=0, pointers=0, out_data=0.
REQ-030 After rst deasserts: in_ready=1 from the first clock edge.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered beats immediately, without waiting for a clock edge.

Verification
REQ-032 NB=4, fwd, d42711aee0bf98f1b8b45de51e415230 -> out_data d4bf5d30e0b452aeb84111f11e2798e5 one cycle later.
REQ-033 NB=4, inv, d4bf5d30e0b452aeb84111f11e2798e5 -> d42711aee0bf98f1b8b45de51e415230.
REQ-034 NB=8, fwd, bytes 00..1f -> first output column 00 05 0e 13; then inv of that result -> bytes 00..1f restored.
REQ-035 out_ready=0, push 3 beats -> count=2, in_ready=0; third beat not accepted; then out_ready=1 -> beats 1, 2 emitted in order.
REQ-036 count=1, push and pop in the same cycle -> count stays 1; 100-beat stream with mixed in_inv -> 100 outputs, no gaps, all matching the model.
REQ-037 count=2, flush=1 with in_valid=1 -> count=0, out_valid=0 next cycle; async rst pulse between edges -> outputs cleared immediately.
